// File: rtl/key_ctrl_if.sv
// Key-state and received-byte bundle between key_ctrl and the movement controller.
interface key_ctrl_if;
    logic       left;
    logic       right;
    logic       jump;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_err;

    modport master (output left, right, jump, byte_data, byte_valid, frame_err);
    modport slave  (input  left, right, jump, byte_data, byte_valid, frame_err);
endinterface

// File: rtl/key_ctrl.sv
// PS/2 set-2 receiver and key-state decoder producing left/right/jump levels.
// Define KEY_CTRL_WASD_EN to also map A/D/W onto left/right/jump.
module key_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 65_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    key_ctrl_if.master  kif
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t      state, state_nxt;
    logic [2:0]  clk_sync;
    logic [1:0]  data_sync;
    logic        fall, bit_in;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        par_bit;
    logic [TW-1:0] tmo_cnt;
    logic        ext, brk;
    logic        h_left, h_right, h_up, h_space;
    logic [7:0]  byte_data_q;
    logic        byte_valid_q, frame_err_q;
    logic        accept, frame_bad, start_err, tmo_hit;
`ifdef KEY_CTRL_WASD_EN
    logic        h_a, h_d, h_w;
`endif

    // Bus idles high, so the synchronisers reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign fall   = clk_sync[2] & ~clk_sync[1];
    assign bit_in = data_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // A falling edge always takes priority over the timeout terminal count.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        frame_bad = 1'b0;
        start_err = 1'b0;
        tmo_hit   = 1'b0;
        if (fall) begin
            case (state)
                IDLE: begin
                    if (!bit_in) state_nxt = DATA;
                    else         start_err = 1'b1;
                end
                DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP: begin
                    state_nxt = IDLE;
                    if (bit_in && ((^shift_reg) ^ par_bit)) accept = 1'b1;
                    else                                     frame_bad = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE && tmo_cnt >= TW'(TIMEOUT_CYCLES - 1)) begin
            state_nxt = IDLE;
            tmo_hit   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            if (fall || tmo_hit)
                tmo_cnt <= '0;
            else if (state != IDLE && tmo_cnt != '1)
                tmo_cnt <= tmo_cnt + 1'b1;

            if (fall) begin
                case (state)
                    IDLE:   bit_cnt <= '0;
                    DATA: begin
                        shift_reg <= {bit_in, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                    PARITY: par_bit <= bit_in;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= accept;
            frame_err_q  <= start_err | frame_bad | tmo_hit;
            if (accept) byte_data_q <= shift_reg;
        end
    end

    // Start-bit errors leave a pending E0/F0 prefix intact; corrupt frames do not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext     <= 1'b0;
            brk     <= 1'b0;
            h_left  <= 1'b0;
            h_right <= 1'b0;
            h_up    <= 1'b0;
            h_space <= 1'b0;
`ifdef KEY_CTRL_WASD_EN
            h_a     <= 1'b0;
            h_d     <= 1'b0;
            h_w     <= 1'b0;
`endif
        end else if (frame_bad || tmo_hit) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (accept) begin
            case (shift_reg)
                8'hE0: ext <= 1'b1;
                8'hF0: brk <= 1'b1;
                default: begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (ext) begin
                        case (shift_reg)
                            8'h6B:   h_left  <= !brk;
                            8'h74:   h_right <= !brk;
                            8'h75:   h_up    <= !brk;
                            default: ;
                        endcase
                    end else begin
                        case (shift_reg)
                            8'h29:   h_space <= !brk;
`ifdef KEY_CTRL_WASD_EN
                            8'h1C:   h_a     <= !brk;
                            8'h23:   h_d     <= !brk;
                            8'h1D:   h_w     <= !brk;
`endif
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

`ifdef KEY_CTRL_WASD_EN
    assign kif.left  = h_left | h_a;
    assign kif.right = h_right | h_d;
    assign kif.jump  = h_up | h_space | h_w;
`else
    assign kif.left  = h_left;
    assign kif.right = h_right;
    assign kif.jump  = h_up | h_space;
`endif
    assign kif.byte_data  = byte_data_q;
    assign kif.byte_valid = byte_valid_q;
    assign kif.frame_err  = frame_err_q;

endmodule
